// File: rtl/axi_wr_slave.sv
// axi_wr_slave: single-outstanding AXI write slave storing into a 32-bit word memory, plus a combinational peek port.
// Latency: AW accepted in IDLE, one cycle per W beat, bvalid the cycle after the final beat; period (awlen+1)+2.
// Backpressure: awready/wready/bvalid are pure state decodes; B is held stable until bready, no AW is taken meanwhile.
//
// Ports: aclk, areset (synchronous, active-high)
//        AW: awid, awaddr, awlen, awsize, awburst, awvalid / awready
//        W : wid, wdata, wstrb, wlast, wvalid / wready
//        B : bid, bresp, bvalid / bready
//        peek_addr / peek_data: zero-latency debug read of the word memory
module axi_wr_slave #(
    parameter int MEM_WORDS = 64
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [3:0]                   awid,
    input  logic [31:0]                  awaddr,
    input  logic [3:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [3:0]                   wid,
    input  logic [31:0]                  wdata,
    input  logic [3:0]                   wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [3:0]                   bid,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [$clog2(MEM_WORDS)-1:0] peek_addr,
    output logic [31:0]                  peek_data
);

    localparam int          AW          = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES   = 33'(MEM_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] mem [MEM_WORDS];

    // Burst context captured on the AW handshake.
    logic [3:0]    cap_id;
    logic [AW-1:0] cap_idx;
    logic [3:0]    cap_len;
    logic          cap_fixed;
    logic          cap_decerr;
    logic          cap_slverr;

    // Beat counter and sticky protocol error (wlast / wid mismatch).
    logic [3:0]    cnt;
    logic          proto_err;

    logic [32:0]   aw_end;
    logic          aw_decerr;
    logic          aw_slverr;
    logic          aw_hs;
    logic          w_hs;
    logic          last_beat;
    logic          beat_err;
    logic          mem_we;
    logic [AW-1:0] cur_idx;

    // Classification of the incoming burst. The end address is formed in
    // 33 bits so a burst that wraps the 32-bit space still decodes as DECERR.
    always_comb begin
        aw_end = {1'b0, awaddr};
        if (awburst != 2'b00) begin
            aw_end = aw_end + {27'd0, awlen, 2'b00};
        end
        aw_decerr = (aw_end >= MEM_BYTES);
        aw_slverr = (awsize != 3'b010) || awburst[1] || (awaddr[1:0] != 2'b00);
    end

    assign aw_hs     = (state == IDLE) && awvalid;
    assign w_hs      = (state == DATA) && wvalid;
    assign last_beat = (cnt == cap_len);

    // A beat is bad if wlast disagrees with the beat count or the ID drifts.
    // The burst still terminates on the counter, not on wlast.
    assign beat_err  = (wlast != last_beat) || (wid != cap_id);

    assign cur_idx   = cap_fixed ? cap_idx : (cap_idx + AW'(cnt));

    // Only bursts classified OKAY at AW time touch memory; protocol errors
    // detected during the data phase still write.
    assign mem_we    = w_hs && !cap_decerr && !cap_slverr && !areset;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and channel handshake outputs (state decodes only).
    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        case (state)
            IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                wready = 1'b1;
                if (wvalid && last_beat) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst context: no reset needed, always rewritten before use.
    always_ff @(posedge aclk) begin
        if (aw_hs && !areset) begin
            cap_id    <= awid;
            cap_idx   <= awaddr[AW+1:2];
            cap_len   <= awlen;
            cap_fixed <= (awburst == 2'b00);
        end
    end

    // Counter, error flags and the B channel payload.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt        <= 4'd0;
            proto_err  <= 1'b0;
            cap_decerr <= 1'b0;
            cap_slverr <= 1'b0;
            bid        <= 4'd0;
            bresp      <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                cnt        <= 4'd0;
                proto_err  <= 1'b0;
                cap_decerr <= aw_decerr;
                cap_slverr <= aw_slverr;
            end
            if (w_hs) begin
                cnt       <= cnt + 4'd1;
                proto_err <= proto_err | beat_err;
                if (last_beat) begin
                    bid <= cap_id;
                    if (cap_decerr) begin
                        bresp <= RESP_DECERR;
                    end else if (cap_slverr || proto_err || beat_err) begin
                        bresp <= RESP_SLVERR;
                    end else begin
                        bresp <= RESP_OKAY;
                    end
                end
            end
        end
    end

    // Byte-enabled word memory; contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[cur_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign peek_data = mem[peek_addr];

endmodule

// File: tb/tb_axi_wr_slave.sv
`timescale 1ns/1ps
module tb_axi_wr_slave;

    localparam int MEM_WORDS = 64;
    localparam int AW        = 6;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [AW-1:0] peek_addr;
    logic [31:0] peek_data;

    axi_wr_slave #(.MEM_WORDS(MEM_WORDS)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .peek_addr(peek_addr), .peek_data(peek_data)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int aw_hs_cyc;
    always @(posedge aclk) cyc <= cyc + 1;

    // Reference memory and per-beat stimulus of the burst being driven.
    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] dut_img   [MEM_WORDS];
    logic [31:0] bdata [16];
    logic [3:0]  bstrb [16];
    logic        blast [16];
    logic [3:0]  bwid  [16];

    // ---------------- reference model ----------------
    // 3 = DECERR, 2 = SLVERR decided at address time, 0 = writable
    function automatic int model_class(input logic [31:0] addr, input logic [3:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        longint e;
        e = (burst == 2'b00) ? longint'(addr) : longint'(addr) + longint'(len) * 4;
        if (e >= longint'(MEM_WORDS * 4)) return 3;
        if (size != 3'b010 || burst > 2'b01 || addr % 4 != 0) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [3:0] id, input logic [31:0] addr,
                                              input logic [3:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        int c;
        c = model_class(addr, len, size, burst);
        if (c == 3) return 2'b11;
        if (c == 2) return 2'b10;
        for (int b = 0; b <= int'(len); b++)
            if (blast[b] != (b == int'(len)) || bwid[b] != id) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_apply(input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        if (model_class(addr, len, size, burst) != 0) return;
        for (int b = 0; b <= int'(len); b++) begin
            int idx;
            idx = int'(addr >> 2) + ((burst == 2'b01) ? b : 0);
            for (int k = 0; k < 4; k++)
                if (bstrb[b][k]) model_mem[idx][8*k +: 8] = bdata[b][8*k +: 8];
        end
    endtask

    // ---------------- drivers ----------------
    task automatic fill_beats(input logic [3:0] id, input logic [3:0] len, input bit rnd_strb);
        for (int b = 0; b < 16; b++) begin
            bdata[b] = $urandom;
            bstrb[b] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            blast[b] = (b == int'(len));
            bwid[b]  = id;
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && t < 50) begin @(posedge aclk); #1; t++; end
        if (!awready) begin
            tests++; fails++;
            $display("FAIL aw_timeout awready=%b required 1", awready);
        end
        @(posedge aclk); #1;
        aw_hs_cyc = cyc;
        awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic [3:0] s,
                             input logic l);
        int t = 0;
        wid = id; wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && t < 50) begin @(posedge aclk); #1; t++; end
        if (!wready) begin
            tests++; fails++;
            $display("FAIL w_timeout wready=%b required 1", wready);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b(input int stall, output logic [3:0] rid, output logic [1:0] rresp);
        int t = 0;
        while (!bvalid && t < 50) begin @(posedge aclk); #1; t++; end
        if (!bvalid) begin
            tests++; fails++;
            $display("FAIL b_timeout bvalid=%b required 1", bvalid);
        end
        rid = bid; rresp = bresp;
        repeat (stall) begin @(posedge aclk); #1; end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             output logic [3:0] rid, output logic [1:0] rresp);
        send_aw(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) send_beat(bwid[b], bdata[b], bstrb[b], blast[b]);
        get_b(0, rid, rresp);
    endtask

    task automatic snap_mem();
        for (int i = 0; i < MEM_WORDS; i++) begin
            peek_addr = AW'(i); #1;
            dut_img[i] = peek_data;
        end
        @(posedge aclk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; wlast = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wid = 0; wdata = 0; wstrb = 0; peek_addr = 0;
        repeat (3) @(posedge aclk);
        #1;
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL rst_awready got %b exp 1", awready); end
        tests++; if (wready  !== 1'b0) begin fails++; $display("FAIL rst_wready got %b exp 0", wready); end
        tests++; if (bvalid  !== 1'b0) begin fails++; $display("FAIL rst_bvalid got %b exp 0", bvalid); end
        tests++; if (bid     !== 4'd0) begin fails++; $display("FAIL rst_bid got %h exp 0", bid); end
        tests++; if (bresp   !== 2'd0) begin fails++; $display("FAIL rst_bresp got %h exp 0", bresp); end
        areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_fill();
        logic [3:0] rid; logic [1:0] rr; int bad;
        for (int q = 0; q < 4; q++) begin
            fill_beats(4'(q), 4'd15, 1'b0);
            model_apply(32'(q * 64), 4'd15, 3'b010, 2'b01);
            run_burst(4'(q), 32'(q * 64), 4'd15, 3'b010, 2'b01, rid, rr);
            tests++; if (rr !== 2'b00) begin fails++; $display("FAIL fill_bresp got %h exp 0", rr); end
        end
        snap_mem();
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL fill_mem bad_words=%0d exp 0", bad); end
    endtask

    task automatic test_incr();
        logic [3:0] rid; logic [1:0] rr;
        fill_beats(4'd5, 4'd3, 1'b0);
        for (int b = 0; b < 4; b++) bdata[b] = 32'hA0 + 32'(b);
        model_apply(32'h10, 4'd3, 3'b010, 2'b01);
        run_burst(4'd5, 32'h10, 4'd3, 3'b010, 2'b01, rid, rr);
        tests++; if (rr !== 2'b00) begin fails++; $display("FAIL incr_bresp got %h exp 0", rr); end
        tests++; if (rid !== 4'd5) begin fails++; $display("FAIL incr_bid got %h exp 5", rid); end
        for (int i = 0; i < 4; i++) begin
            peek_addr = AW'(4 + i); #1;
            tests++;
            if (peek_data !== 32'hA0 + 32'(i)) begin
                fails++; $display("FAIL incr_word%0d got %h exp %h", 4 + i, peek_data, 32'hA0 + 32'(i));
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_fixed();
        logic [3:0] rid; logic [1:0] rr; int bad;
        fill_beats(4'd3, 4'd2, 1'b0);
        bdata[0] = 32'h11; bdata[1] = 32'h22; bdata[2] = 32'h33;
        bstrb[0] = 4'hF;   bstrb[1] = 4'hF;   bstrb[2] = 4'h1;
        model_apply(32'h20, 4'd2, 3'b010, 2'b00);
        run_burst(4'd3, 32'h20, 4'd2, 3'b010, 2'b00, rid, rr);
        tests++; if (rr !== 2'b00) begin fails++; $display("FAIL fixed_bresp got %h exp 0", rr); end
        peek_addr = AW'(8); #1;
        tests++; if (peek_data !== 32'h33) begin fails++; $display("FAIL fixed_word8 got %h exp 00000033", peek_data); end
        snap_mem();
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL fixed_mem bad_words=%0d exp 0", bad); end
    endtask

    task automatic test_decerr();
        logic [3:0] rid; logic [1:0] rr; int bad;
        fill_beats(4'd7, 4'd3, 1'b0);
        model_apply(32'hF8, 4'd3, 3'b010, 2'b01);
        run_burst(4'd7, 32'hF8, 4'd3, 3'b010, 2'b01, rid, rr);
        tests++; if (rr !== 2'b11) begin fails++; $display("FAIL decerr_bresp got %h exp 3", rr); end
        snap_mem();
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL decerr_mem bad_words=%0d exp 0", bad); end
    endtask

    task automatic test_slverr();
        logic [3:0] rid; logic [1:0] rr; int bad;
        fill_beats(4'd2, 4'd1, 1'b0);
        blast[0] = 1'b1; blast[1] = 1'b0;
        model_apply(32'h80, 4'd1, 3'b010, 2'b01);
        run_burst(4'd2, 32'h80, 4'd1, 3'b010, 2'b01, rid, rr);
        tests++; if (rr !== 2'b10) begin fails++; $display("FAIL wlast_bresp got %h exp 2", rr); end
        fill_beats(4'd4, 4'd1, 1'b0);
        model_apply(32'h90, 4'd1, 3'b001, 2'b01);
        run_burst(4'd4, 32'h90, 4'd1, 3'b001, 2'b01, rid, rr);
        tests++; if (rr !== 2'b10) begin fails++; $display("FAIL size_bresp got %h exp 2", rr); end
        snap_mem();
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL slverr_mem bad_words=%0d exp 0", bad); end
    endtask

    task automatic test_bready_stall();
        int bad = 0;
        fill_beats(4'd9, 4'd1, 1'b0);
        model_apply(32'h30, 4'd1, 3'b010, 2'b01);
        send_aw(4'd9, 32'h30, 4'd1, 3'b010, 2'b01);
        for (int b = 0; b < 2; b++) send_beat(bwid[b], bdata[b], bstrb[b], blast[b]);
        for (int c = 0; c < 5; c++) begin
            if (bvalid !== 1'b1 || bid !== 4'd9 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                bad++;
                $display("FAIL stall_c%0d bvalid=%b bid=%h bresp=%h awready=%b exp 1/9/0/0", c, bvalid, bid, bresp, awready);
            end
            @(posedge aclk); #1;
        end
        tests++; if (bad != 0) fails++;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        tests++; if (bvalid !== 1'b0) begin fails++; $display("FAIL stall_release_bvalid got %b exp 0", bvalid); end
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL stall_release_awready got %b exp 1", awready); end
    endtask

    task automatic test_ignore();
        int bad = 0;
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wid = 4'd0; wlast = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge aclk); #1;
            if (wready !== 1'b0 || awready !== 1'b1) bad++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_wvalid bad_cycles=%0d exp 0", bad); end
        snap_mem();
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_wvalid_mem bad_words=%0d exp 0", bad); end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] rid; logic [1:0] rr; int bad = 0;
        fill_beats(4'd6, 4'd3, 1'b0);
        send_aw(4'd6, 32'h40, 4'd3, 3'b010, 2'b01);
        send_beat(bwid[0], bdata[0], bstrb[0], blast[0]);
        send_beat(bwid[1], bdata[1], bstrb[1], blast[1]);
        model_apply(32'h40, 4'd1, 3'b010, 2'b01);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL midrst_awready got %b exp 1", awready); end
        tests++; if (wready !== 1'b0) begin fails++; $display("FAIL midrst_wready got %b exp 0", wready); end
        for (int c = 0; c < 4; c++) begin
            if (bvalid !== 1'b0) bad++;
            @(posedge aclk); #1;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL midrst_bvalid cycles_high=%0d exp 0", bad); end
        snap_mem();
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL midrst_mem bad_words=%0d exp 0", bad); end
        fill_beats(4'd1, 4'd3, 1'b0);
        model_apply(32'h50, 4'd3, 3'b010, 2'b01);
        run_burst(4'd1, 32'h50, 4'd3, 3'b010, 2'b01, rid, rr);
        tests++; if (rr !== 2'b00 || rid !== 4'd1) begin
            fails++; $display("FAIL midrst_next bresp=%h bid=%h exp 0/1", rr, rid);
        end
    endtask

    task automatic test_random();
        logic [3:0] id, len, rid; logic [2:0] size; logic [1:0] burst, rr, exp;
        logic [31:0] addr; int r, bad;
        for (int n = 0; n < 40; n++) begin
            id  = 4'($urandom_range(0, 15));
            len = 4'($urandom_range(0, 15));
            r   = int'($urandom_range(0, 9));
            burst = (r < 5) ? 2'b01 : (r < 8) ? 2'b00 : 2'($urandom_range(2, 3));
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            addr  = 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) addr = 32'hFFFF_FFF0;
            fill_beats(id, len, 1'b1);
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, int'(len)));
                blast[r] = ~blast[r];
            end
            if ($urandom_range(0, 5) == 0) bwid[$urandom_range(0, int'(len))] = id ^ 4'h1;
            exp = model_resp(id, addr, len, size, burst);
            model_apply(addr, len, size, burst);
            run_burst(id, addr, len, size, burst, rid, rr);
            tests++; if (rr !== exp) begin fails++; $display("FAIL rand%0d_bresp got %h exp %h", n, rr, exp); end
            tests++; if (rid !== id) begin fails++; $display("FAIL rand%0d_bid got %h exp %h", n, rid, id); end
            snap_mem();
            bad = 0;
            for (int i = 0; i < MEM_WORDS; i++) if (dut_img[i] !== model_mem[i]) bad++;
            tests++; if (bad != 0) begin fails++; $display("FAIL rand%0d_mem bad_words=%0d exp 0", n, bad); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rid, len, prev_len; logic [1:0] rr; int prev_cyc;
        prev_len = 4'd0; prev_cyc = 0;
        for (int n = 0; n < 4; n++) begin
            len = 4'($urandom_range(0, 15));
            fill_beats(4'(n), len, 1'b0);
            model_apply(32'h0, len, 3'b010, 2'b01);
            send_aw(4'(n), 32'h0, len, 3'b010, 2'b01);
            if (n > 0) begin
                tests++;
                if (aw_hs_cyc - prev_cyc != int'(prev_len) + 3) begin
                    fails++;
                    $display("FAIL b2b%0d_period got %0d exp %0d", n, aw_hs_cyc - prev_cyc, int'(prev_len) + 3);
                end
            end
            prev_cyc = aw_hs_cyc; prev_len = len;
            for (int b = 0; b <= int'(len); b++) send_beat(bwid[b], bdata[b], bstrb[b], blast[b]);
            get_b(0, rid, rr);
            tests++; if (rr !== 2'b00) begin fails++; $display("FAIL b2b%0d_bresp got %h exp 0", n, rr); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_incr();
        test_fixed();
        test_decerr();
        test_slverr();
        test_bready_stall();
        test_ignore();
        test_reset_mid_burst();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in internal storage (power of two, 4..1024).
REQ-002 aclk  input  1  clock; all logic is on the rising edge.
REQ-003 areset  input  1  reset; one clock, synchronous, active-high.
REQ-004 awid  input  4  write address ID.
REQ-005 awaddr  input  32  burst start byte address.
REQ-006 awlen  input  4  beats minus one (1..16 beats).
REQ-007 awsize  input  3  beat size; only 3'b010 (4 bytes) is legal.
REQ-008 awburst  input  2  burst type: 00 FIXED, 01 INCR, others illegal.
REQ-009 awvalid  input  1  AW valid.
REQ-010 awready  output  1  AW ready.
REQ-011 wid  input  4  write data ID.
REQ-012 wdata  input  32  write data.
REQ-013 wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
REQ-014 wlast  input  1  last beat marker.
REQ-015 wvalid  input  1  W valid.
REQ-016 wready  output  1  W ready.
REQ-017 bid  output  4  response ID.
REQ-018 bresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-019 bvalid  output  1  B valid.
REQ-020 bready  input  1  B ready.
REQ-021 peek_addr  input  log2(MEM_WORDS)  word index for a combinational debug read.
REQ-022 peek_data  output  32  the current contents of mem[peek_addr], with no latency.

Function
REQ-023 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, with one write burst outstanding.
- IDLE: awready=1.
- DATA: wready=1.
- RESP: bvalid=1.
- All other ready/valid outputs are 0 in each state.
REQ-024 On the AW handshake in IDLE, SHALL capture awid, awaddr, awlen, awsize and awburst, and go to DATA; wready is asserted the next cycle.
REQ-025 SHALL classify the burst at AW capture, highest priority first:
- DECERR if the end address is at or beyond MEM_WORDS*4 (end = awaddr for FIXED; awaddr + awlen*4 for INCR).
- Otherwise SLVERR if awsize != 3'b010, awburst is not 00/01, or awaddr[1:0] != 0.
- Otherwise OKAY.
REQ-026 On each W handshake of an OKAY burst, SHALL write each enabled byte of the current word; disabled bytes are unchanged.
- Current word is awaddr[..:2] plus beat count for INCR, and constant for FIXED.
REQ-027 SHALL accept the data beats of an error burst but discard them, leaving memory untouched.
REQ-028 SHALL count beats with a 4-bit counter. The burst ends on the handshake where count == captured awlen, whatever the value of wlast.
REQ-029 SHALL set bresp to SLVERR if:
- wlast is mismatched (asserted early, or absent on the final beat); or
- wid differs from the captured awid on any beat.
Beats are still written in both cases. DECERR overrides SLVERR.
REQ-030 On the final W handshake, SHALL go to RESP; bvalid rises the next cycle, with bid equal to the captured awid.
REQ-031 In RESP, SHALL hold bvalid, bid and bresp stable until bready=1, then return to IDLE; awready=1 on the following cycle.
REQ-032 SHALL never combinationally depend awready, wready or bvalid on any input in the same cycle; all three are registered state decodes.
REQ-033 SHALL ignore wvalid in IDLE and RESP, and awvalid in DATA and RESP.
REQ-034 The minimum burst period SHALL be (awlen+1)+2 cycles when valids and bready are held high.

Reset
REQ-035 While areset=1 at a clock edge, SHALL enter IDLE and clear the beat counter and error flags.
- Next cycle outputs: awready=1, wready=0, bvalid=0, bid=0, bresp=00.
REQ-036 Reset in the middle of a burst SHALL abandon it with no B response; words already written keep their values.
REQ-037 Memory contents SHALL NOT be cleared by reset; the bench preloads or writes before it checks.

Verification
REQ-038 INCR, awaddr=0x10, awlen=3, wstrb=F, data A0..A3 -> peek 4..7 = A0..A3; bresp=00; bid=awid.
REQ-039 FIXED, awaddr=0x20, awlen=2, data 11/22/33, wstrb=F/F/1 -> peek 8 = 0x00000033 over prior 0x22; bresp=00.
REQ-040 INCR, awaddr=0xF8, awlen=3 (MEM_WORDS=64) -> all 4 beats accepted, memory unchanged, bresp=11.
REQ-041 awlen=1 with wlast on beat 0 -> both beats written, bresp=10; separately, awsize=3'b001 -> no write, bresp=10.
REQ-042 bready held low for 5 cycles in RESP -> bvalid, bid and bresp are stable, awready=0 throughout; IDLE follows bready.
REQ-043 areset pulsed after beat 1 of a 4-beat INCR burst -> no bvalid, awready=1 next cycle, beats 0-1 retained, and a new burst completes OKAY.
